// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
//   ADDRESS_LEN : default address/instruction width
//   NOP_INSTR   : instruction word presented to ID when no real instruction is held
//   PC_STEP     : byte distance between consecutive instructions
package if_fetch_unit_pkg;

    localparam int unsigned ADDRESS_LEN = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int unsigned PC_STEP     = 4;

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// In-order fetch queue with synchronous flush.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to store
//   pop        : drop the head entry (caller guarantees non-empty)
//   flush      : discard all entries (wins over push/pop)
//   count      : number of valid entries
//   head       : oldest entry, meaningful when count != 0
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    // Upstream reserves a slot per request, so a push into a full queue is a design bug.
    always_ff @(posedge clk) begin
        if (!rst && !flush) assert (!(push && !pop && (count_q == CNT_W'(DEPTH))));
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage and IF/ID pipeline register.
//   clk, rst        : clock, synchronous active-high reset
//   freeze          : ID stall, IF/ID register holds
//   branch_taken    : EXE redirect; flushes queue and IF/ID, drops in-flight words
//   branch_addr     : redirect target (word aligned)
//   imem_req/addr   : fetch request and its address (addr = fetch PC)
//   imem_gnt        : request accepted this cycle
//   imem_rvalid/rdata : in-order instruction return
//   id_valid/pc/instruction : IF/ID register (pc is instruction address + 4)
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned      ADDR_W          = ADDRESS_LEN,
    parameter int unsigned      QUEUE_DEPTH     = 2,
    parameter int unsigned      MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_instruction
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = $clog2(QUEUE_DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] NOP  = ADDR_W'(NOP_INSTR);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [ADDR_W-1:0] id_instr_q, id_instr_d;

    logic [CNT_W-1:0]    q_count;
    logic [2*ADDR_W-1:0] q_head;
    logic [SUM_W-1:0]    used_c;
    logic                pop_c, req_c, hs_c, push_c;

    // Queue pop and request gating. A head popped this cycle frees its slot for
    // a new request, which is what sustains one instruction per cycle.
    always_comb begin
        pop_c  = !rst && !branch_taken && !freeze && (q_count != '0);
        used_c = SUM_W'(q_count) + SUM_W'(out_cnt_q) - SUM_W'(pop_c);
        req_c  = !rst && !branch_taken
                 && (used_c < SUM_W'(QUEUE_DEPTH))
                 && (out_cnt_q < OUT_W'(MAX_OUTSTANDING));
        hs_c   = req_c && imem_gnt;
        push_c = !rst && imem_rvalid && !branch_taken && (drop_cnt_q == '0);
    end

    fetch_fifo #(
        .WIDTH (2 * ADDR_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data ({resp_pc_q + STEP, imem_rdata}),
        .pop       (pop_c),
        .flush     (branch_taken),
        .count     (q_count),
        .head      (q_head)
    );

    // Fetch PC, in-flight bookkeeping and IF/ID register next state.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        out_cnt_d  = out_cnt_q + OUT_W'(hs_c) - OUT_W'(imem_rvalid);

        if (hs_c) fetch_pc_d = fetch_pc_q + STEP;

        // resp_pc tracks the address of the next non-discarded response.
        if (imem_rvalid) begin
            if (drop_cnt_q != '0)   drop_cnt_d = drop_cnt_q - OUT_W'(1);
            else if (!branch_taken) resp_pc_d  = resp_pc_q + STEP;
        end

        if (branch_taken) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = branch_addr;
            resp_pc_d  = branch_addr;
            drop_cnt_d = out_cnt_d;
            id_valid_d = 1'b0;
            id_pc_d    = '0;
            id_instr_d = NOP;
        end else if (freeze) begin
            id_valid_d = id_valid_q;
        end else if (q_count != '0) begin
            id_valid_d = 1'b1;
            id_pc_d    = q_head[2*ADDR_W-1:ADDR_W];
            id_instr_d = q_head[ADDR_W-1:0];
        end else begin
            id_valid_d = 1'b0;
            id_pc_d    = '0;
            id_instr_d = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign imem_req       = req_c;
    assign imem_addr      = fetch_pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_instruction = id_instr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, randomized run against a
// queue-based reference model, and a wrap/reset sequence on a second instance.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, freeze, branch_taken, imem_gnt, imem_rvalid;
    logic [31:0] branch_addr, imem_rdata;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_pc, id_instruction;

    if_fetch_unit #(
        .ADDR_W(32), .QUEUE_DEPTH(2), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_instruction(id_instruction)
    );

    // Second instance: high reset PC, always granted, fixed one-cycle return.
    logic        w_rst, w_rv, w_req, w_valid;
    logic [31:0] w_addr, w_pc, w_instr;

    if_fetch_unit #(
        .ADDR_W(32), .QUEUE_DEPTH(2), .MAX_OUTSTANDING(2), .RESET_PC(32'hFFFF_FFF8)
    ) dut_w (
        .clk(clk), .rst(w_rst), .freeze(1'b0), .branch_taken(1'b0),
        .branch_addr(32'h0), .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(1'b1), .imem_rvalid(w_rv), .imem_rdata(32'h1234_5678),
        .id_valid(w_valid), .id_pc(w_pc), .id_instruction(w_instr)
    );

    always @(posedge clk) w_rv <= !w_rst && w_req;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Instruction memory contents: word i holds i, tagged in the top byte.
    function automatic logic [31:0] mw(input logic [31:0] idx);
        return idx ^ 32'hA500_0000;
    endfunction

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] addr; bit stale; } infl_t;
    typedef struct { logic [31:0] pc4; logic [31:0] ins; } qent_t;
    typedef struct { logic [31:0] addr; int c; } acc_t;

    infl_t       m_infl[$];
    qent_t       m_q[$];
    acc_t        imem_q[$];
    logic [31:0] m_pc, m_idpc, m_ins;
    bit          m_vld;

    task automatic model_reset();
        m_infl.delete();
        m_q.delete();
        imem_q.delete();
        m_pc   = 32'h0;
        m_vld  = 1'b0;
        m_idpc = 32'h0;
        m_ins  = 32'h0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check request, advance model.
    task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba,
                        input bit g, input bit rv_ok);
        bit    pop, req;
        int    used;
        qent_t e;
        infl_t inf;
        chk("id_valid", 32'(id_valid), 32'(m_vld));
        chk("id_pc", id_pc, m_idpc);
        chk("id_instr", id_instruction, m_ins);

        rst = r; freeze = f; branch_taken = b; branch_addr = ba; imem_gnt = g;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (!r && rv_ok && imem_q.size() > 0 && imem_q[0].c < cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mw(imem_q[0].addr >> 2);
            void'(imem_q.pop_front());
        end
        #1;
        pop  = !r && !b && !f && m_q.size() > 0;
        used = m_q.size() - int'(pop) + m_infl.size();
        req  = !r && !b && used < 2 && m_infl.size() < 2;
        chk("imem_req", 32'(imem_req), 32'(req));
        if (req) chk("imem_addr", imem_addr, m_pc);
        if (!r && imem_req && g) imem_q.push_back('{imem_addr, cyc});

        if (r) begin
            model_reset();
        end else begin
            if (b) begin
                m_vld = 1'b0; m_idpc = 32'h0; m_ins = 32'h0;
                m_q.delete();
                foreach (m_infl[i]) m_infl[i].stale = 1'b1;
                m_pc = ba;
            end else if (!f) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    m_vld = 1'b1; m_idpc = e.pc4; m_ins = e.ins;
                end else begin
                    m_vld = 1'b0; m_idpc = 32'h0; m_ins = 32'h0;
                end
            end
            if (imem_rvalid && m_infl.size() > 0) begin
                inf = m_infl.pop_front();
                if (!inf.stale && !b) m_q.push_back('{inf.addr + 32'd4, mw(inf.addr >> 2)});
            end
            if (req && g) begin
                m_infl.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit f, b; logic [31:0] ba; bit g, stall;
        bit ev; logic [31:0] epc, eins;
        bit ca, er; logic [31:0] ea;
    } row_t;
    localparam int NROWS = 32;
    row_t tbl[NROWS];

    task automatic ex(input int k, input logic [31:0] pc, input logic [31:0] idx);
        tbl[k].ev = 1'b1; tbl[k].epc = pc; tbl[k].eins = mw(idx);
    endtask

    task automatic ad(input int k, input bit r, input logic [31:0] a);
        tbl[k].ca = 1'b1; tbl[k].er = r; tbl[k].ea = a;
    endtask

    initial begin
        for (int k = 0; k < NROWS; k++)
            tbl[k] = '{f:1'b0, b:1'b0, ba:32'h0, g:1'b1, stall:1'b0, ev:1'b0,
                       epc:32'h0, eins:32'h0, ca:1'b0, er:1'b0, ea:32'h0};
        // back-to-back stream, then 3-cycle freeze while id_pc=8
        ex(3, 32'd4, 0);
        for (int k = 4; k <= 7; k++) ex(k, 32'd8, 1);
        for (int k = 8; k <= 11; k++) ex(k, 32'(4 * (k - 5)), 32'(k - 6));
        for (int k = 4; k <= 6; k++) tbl[k].f = 1'b1;
        // hold one return so two requests are in flight, then redirect to 0x40
        tbl[10].stall = 1'b1;
        tbl[11].b = 1'b1; tbl[11].ba = 32'h40;
        ex(15, 32'h44, 16); ex(16, 32'h48, 17); ex(17, 32'h4C, 18);
        // redirect together with freeze
        tbl[17].b = 1'b1; tbl[17].f = 1'b1; tbl[17].ba = 32'h100;
        ex(21, 32'h104, 64); ex(22, 32'h108, 65); ex(23, 32'h10C, 66); ex(24, 32'h110, 67);
        // grant withheld for five cycles
        for (int k = 22; k <= 26; k++) tbl[k].g = 1'b0;
        ex(30, 32'h114, 68); ex(31, 32'h118, 69);
        ad(0, 1'b1, 32'h0); ad(1, 1'b1, 32'h4); ad(2, 1'b1, 32'h8); ad(3, 1'b1, 32'hC);
        ad(4, 1'b0, 32'h0); ad(11, 1'b0, 32'h0); ad(12, 1'b1, 32'h40); ad(18, 1'b1, 32'h100);
        for (int k = 22; k <= 27; k++) ad(k, 1'b1, 32'h110);

        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; w_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instruction, 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        model_reset();
        cyc = 0;

        for (int k = 0; k < NROWS; k++) begin
            step(1'b0, tbl[k].f, tbl[k].b, tbl[k].ba, tbl[k].g, !tbl[k].stall);
            chk("tbl_valid", 32'(id_valid), 32'(tbl[k].ev));
            if (tbl[k].ev) begin
                chk("tbl_pc", id_pc, tbl[k].epc);
                chk("tbl_instr", id_instruction, tbl[k].eins);
            end else begin
                chk("tbl_nop", id_instruction, 32'h0);
            end
            if (tbl[k].ca) begin
                chk("tbl_req", 32'(imem_req), 32'(tbl[k].er));
                if (tbl[k].er) chk("tbl_addr", imem_addr, tbl[k].ea);
            end
            @(negedge clk);
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit r, f, b, g, rv;
            logic [31:0] ba;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 15) == 0);
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                             : ($urandom() & 32'hFFFF_FFFC);
            g  = ($urandom_range(0, 9) < 7);
            rv = ($urandom_range(0, 9) < 6);
            step(r, f, b, ba, g, rv);
            @(negedge clk);
        end
        rst = 1'b1;

        // address wrap from a high reset PC, then a mid-stream reset
        w_rst = 1'b0;
        #1;
        chk("w_req0", 32'(w_req), 32'h1);
        chk("w_addr0", w_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("w_addr1", w_addr, 32'hFFFF_FFFC);
        chk("w_valid1", 32'(w_valid), 32'h0);
        @(negedge clk);
        chk("w_req2", 32'(w_req), 32'h1);
        chk("w_addr2", w_addr, 32'h0000_0000);
        @(negedge clk);
        chk("w_valid3", 32'(w_valid), 32'h1);
        chk("w_pc3", w_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("w_pc4", w_pc, 32'h0000_0000);
        w_rst = 1'b1;
        @(negedge clk);
        #1;
        chk("w_rst_valid", 32'(w_valid), 32'h0);
        chk("w_rst_pc", w_pc, 32'h0);
        chk("w_rst_instr", w_instr, 32'h0);
        chk("w_rst_req", 32'(w_req), 32'h0);
        chk("w_rst_addr", w_addr, 32'hFFFF_FFF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
